// File: rtl/date_preset_display_pkg.sv
// Shared constants, segment decode and FSM state type for the preset-date display.
package date_display_pkg;

  // Active-low seven-segment codes, bit order gfedcba (bit 6 = g).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    SHOW  = 2'd1,
    AUTO  = 2'd2
  } state_t;

  // Non-decimal codes 10-15 blank the digit rather than showing garbage.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/date_preset_display_btn_debounce.sv
// One active-low button: 2-flop synchroniser, stability counter and press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;

  // Bring the raw pin into the clock domain; reset to released so no false press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= {CW{1'b0}};
      r_level <= 1'b1;
    end else if (r_sync2 == r_level) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= {CW{1'b0}};
      r_level <= r_sync2;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // One-cycle pulse on the debounced 1->0 (press) edge; release is ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level_d <= 1'b1;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level_d & ~r_level;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/date_preset_display.sv
// Preset-date display controller: debounced buttons pick a BCD preset,
// optional auto-rotate cycles through presets, registered seven-segment decode.
module date_preset_display
  import date_display_pkg::*;
#(
  parameter int NUM_DIGITS      = 6,
  parameter int NUM_PRESETS     = 3,
  parameter logic [NUM_PRESETS*NUM_DIGITS*4-1:0] PRESET_BCD = 72'h800817_800726_860822,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ROTATE_CYCLES   = 50000000
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_PRESETS-1:0]         i_btn_n,
  input  logic                           i_auto_en,
  output logic [7*NUM_DIGITS-1:0]        o_seg,
  output logic [$clog2(NUM_PRESETS)-1:0] o_active_idx,
  output logic                           o_showing
);

  localparam int IW = $clog2(NUM_PRESETS);
  localparam int TW = $clog2(ROTATE_CYCLES + 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_PRESETS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ROTATE_CYCLES - 1);

  logic [NUM_PRESETS-1:0] w_press;
  logic                   w_press_any;
  logic [IW-1:0]          w_press_idx;
  logic [3:0]             w_digit [NUM_DIGITS];

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [TW-1:0]           r_timer;
  logic                    r_showing;
  logic [7*NUM_DIGITS-1:0] r_seg;

  genvar g;
  generate
    for (g = 0; g < NUM_PRESETS; g++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn_n(i_btn_n[g]),
        .o_press(w_press[g])
      );
    end
  endgenerate

  // Simultaneous presses: scan from the top so the lowest index is the one kept.
  always_comb begin
    w_press_any = |w_press;
    w_press_idx = {IW{1'b0}};
    for (int i = NUM_PRESETS - 1; i >= 0; i--) begin
      w_press_idx = w_press[i] ? IW'(i) : w_press_idx;
    end
  end

  // Mode FSM with rotate timer; an auto_en change is applied before the press rule.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= BLANK;
      r_idx     <= {IW{1'b0}};
      r_timer   <= {TW{1'b0}};
      r_showing <= 1'b0;
    end else begin
      case (r_state)
        BLANK: begin
          if (i_auto_en) begin
            r_state   <= AUTO;
            r_showing <= 1'b1;
            r_timer   <= {TW{1'b0}};
            r_idx     <= w_press_any ? w_press_idx : {IW{1'b0}};
          end else if (w_press_any) begin
            r_state   <= SHOW;
            r_showing <= 1'b1;
            r_idx     <= w_press_idx;
          end else begin
            r_showing <= 1'b0;
          end
        end
        SHOW: begin
          if (i_auto_en) begin
            r_state   <= AUTO;
            r_showing <= 1'b1;
            r_timer   <= {TW{1'b0}};
            r_idx     <= w_press_any ? w_press_idx : r_idx;
          end else if (w_press_any && (w_press_idx == r_idx)) begin
            r_state   <= BLANK;
            r_showing <= 1'b0;
          end else if (w_press_any) begin
            r_idx     <= w_press_idx;
            r_showing <= 1'b1;
          end else begin
            r_showing <= 1'b1;
          end
        end
        AUTO: begin
          if (!i_auto_en) begin
            r_timer <= {TW{1'b0}};
            if (w_press_any && (w_press_idx == r_idx)) begin
              r_state   <= BLANK;
              r_showing <= 1'b0;
            end else if (w_press_any) begin
              r_state   <= SHOW;
              r_showing <= 1'b1;
              r_idx     <= w_press_idx;
            end else begin
              r_state   <= SHOW;
              r_showing <= 1'b1;
            end
          end else if (w_press_any) begin
            r_idx     <= w_press_idx;
            r_timer   <= {TW{1'b0}};
            r_showing <= 1'b1;
          end else if (r_timer == TIMER_LAST) begin
            r_idx     <= (r_idx == IDX_LAST) ? {IW{1'b0}} : r_idx + IW'(1);
            r_timer   <= {TW{1'b0}};
            r_showing <= 1'b1;
          end else begin
            r_timer   <= r_timer + TW'(1);
            r_showing <= 1'b1;
          end
        end
        default: begin
          r_state   <= BLANK;
          r_idx     <= {IW{1'b0}};
          r_timer   <= {TW{1'b0}};
          r_showing <= 1'b0;
        end
      endcase
    end
  end

  // Select the BCD nibbles of the preset currently latched.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_digit[i] = PRESET_BCD[(int'(r_idx) * NUM_DIGITS + i) * 4 +: 4];
    end
  end

  // Registered decode: blank every digit while no preset is shown.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_seg[7*i +: 7] <= r_showing ? bcd_to_seg(w_digit[i]) : SEG_BLANK;
      end
    end
  end

  assign o_seg        = r_seg;
  assign o_active_idx = r_idx;
  assign o_showing    = r_showing;

endmodule

// File: tb/tb_date_preset_display.sv
// Directed bench for date_preset_display with short debounce/rotate periods.
module tb_date_preset_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SB = 7'b1111111;

  localparam logic [41:0] D_BLANK = {SB, SB, SB, SB, SB, SB};
  localparam logic [41:0] D_P0    = {S8, S6, S0, S8, S2, S2};  // 860822
  localparam logic [41:0] D_P1    = {S8, S0, S0, S7, S2, S6};  // 800726
  localparam logic [41:0] D_P2    = {S8, S0, S0, S8, S1, S7};  // 800817
  localparam logic [41:0] D_P0C   = {S8, S6, SB, S8, S2, S2};  // 86C822

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  btn_n;
  logic        auto_en;
  logic [41:0] seg;
  logic [1:0]  idx;
  logic        showing;

  logic [2:0]  btn2_n;
  logic        auto2;
  logic [41:0] seg2;
  logic [1:0]  idx2;
  logic        showing2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  date_preset_display #(
    .NUM_DIGITS(6), .NUM_PRESETS(3), .PRESET_BCD(72'h800817_800726_860822),
    .DEBOUNCE_CYCLES(4), .ROTATE_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_n(btn_n), .i_auto_en(auto_en),
    .o_seg(seg), .o_active_idx(idx), .o_showing(showing)
  );

  date_preset_display #(
    .NUM_DIGITS(6), .NUM_PRESETS(3), .PRESET_BCD(72'h800817_800726_86C822),
    .DEBOUNCE_CYCLES(4), .ROTATE_CYCLES(16)
  ) dut_c (
    .i_clk(clk), .i_rst(rst), .i_btn_n(btn2_n), .i_auto_en(auto2),
    .o_seg(seg2), .o_active_idx(idx2), .o_showing(showing2)
  );

  typedef struct {
    string       name;
    logic [2:0]  btn_n;
    logic        auto_en;
    int          cycles;
    logic [41:0] seg;
    logic [1:0]  idx;
    logic        show;
    logic        chk_idx;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string name, input logic [41:0] e_seg,
                           input logic [1:0] e_idx, input logic e_show);
    check({name, "_seg"}, 64'(seg), 64'(e_seg));
    check({name, "_idx"}, 64'(idx), 64'(e_idx));
    check({name, "_show"}, 64'(showing), 64'(e_show));
  endtask

  initial begin
    vecs[0]  = '{"rst_state",    3'b111, 1'b0, 2,  D_BLANK, 2'd0, 1'b0, 1'b1};
    vecs[1]  = '{"p0_early",     3'b110, 1'b0, 7,  D_BLANK, 2'd0, 1'b0, 1'b1};
    vecs[2]  = '{"p0_state",     3'b110, 1'b0, 1,  D_BLANK, 2'd0, 1'b1, 1'b1};
    vecs[3]  = '{"p0_seg",       3'b110, 1'b0, 1,  D_P0,    2'd0, 1'b1, 1'b1};
    vecs[4]  = '{"p0_release",   3'b111, 1'b0, 10, D_P0,    2'd0, 1'b1, 1'b1};
    vecs[5]  = '{"b1_bounce",    3'b101, 1'b0, 3,  D_P0,    2'd0, 1'b1, 1'b1};
    vecs[6]  = '{"b1_bounce_end",3'b111, 1'b0, 10, D_P0,    2'd0, 1'b1, 1'b1};
    vecs[7]  = '{"b1_press",     3'b101, 1'b0, 10, D_P1,    2'd1, 1'b1, 1'b1};
    vecs[8]  = '{"b1_release",   3'b111, 1'b0, 10, D_P1,    2'd1, 1'b1, 1'b1};
    vecs[9]  = '{"b1_toggle",    3'b101, 1'b0, 10, D_BLANK, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{"b1_rel_blank", 3'b111, 1'b0, 10, D_BLANK, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{"simul_0_2",    3'b010, 1'b0, 10, D_P0,    2'd0, 1'b1, 1'b1};
    vecs[12] = '{"simul_rel",    3'b111, 1'b0, 10, D_P0,    2'd0, 1'b1, 1'b1};
    vecs[13] = '{"b1_again",     3'b101, 1'b0, 10, D_P1,    2'd1, 1'b1, 1'b1};
    vecs[14] = '{"b1_rel_again", 3'b111, 1'b0, 10, D_P1,    2'd1, 1'b1, 1'b1};

    rst = 1'b1; btn_n = 3'b111; auto_en = 1'b0; btn2_n = 3'b111; auto2 = 1'b0;
    wait_neg(3);
    check_all("in_reset", D_BLANK, 2'd0, 1'b0);
    rst = 1'b0;

    // Table: each record drives inputs at a negedge, then waits and compares.
    for (int v = 0; v < 15; v++) begin
      btn_n   = vecs[v].btn_n;
      auto_en = vecs[v].auto_en;
      wait_neg(vecs[v].cycles);
      check({vecs[v].name, "_seg"}, 64'(seg), 64'(vecs[v].seg));
      check({vecs[v].name, "_show"}, 64'(showing), 64'(vecs[v].show));
      if (vecs[v].chk_idx) check({vecs[v].name, "_idx"}, 64'(idx), 64'(vecs[v].idx));
    end

    // Auto rotate from SHOW idx 1; btn 1 press lands at cycle 20 and restarts the period.
    auto_en = 1'b1;
    wait_neg(13);
    btn_n = 3'b101;
    wait_neg(3);
    check_all("auto_c16", D_P1, 2'd1, 1'b1);
    wait_neg(1);
    check("auto_c17_idx", 64'(idx), 64'd2);
    check("auto_c17_seg", 64'(seg), 64'(D_P1));
    wait_neg(1);
    check("auto_c18_seg", 64'(seg), 64'(D_P2));
    wait_neg(2);
    check("auto_c20_idx", 64'(idx), 64'd2);
    wait_neg(1);
    check("auto_press_idx", 64'(idx), 64'd1);
    btn_n = 3'b111;
    wait_neg(15);
    check("auto_c36_idx", 64'(idx), 64'd1);
    wait_neg(1);
    check("auto_c37_idx", 64'(idx), 64'd2);
    wait_neg(15);
    check("auto_c52_idx", 64'(idx), 64'd2);
    wait_neg(1);
    check("auto_wrap_idx", 64'(idx), 64'd0);
    wait_neg(1);
    check_all("auto_wrap", D_P0, 2'd0, 1'b1);

    // Leaving auto keeps the current preset and stops rotating.
    auto_en = 1'b0;
    wait_neg(21);
    check_all("auto_off", D_P0, 2'd0, 1'b1);

    // Reset asserted mid-auto clears outputs without waiting for a clock edge.
    auto_en = 1'b1;
    wait_neg(18);
    check_all("auto_pre_rst", D_P1, 2'd1, 1'b1);
    #2;
    rst = 1'b1;
    btn_n = 3'b011;
    #1;
    check_all("async_rst", D_BLANK, 2'd0, 1'b0);
    wait_neg(3);
    auto_en = 1'b0;
    rst = 1'b0;
    // Button 2 held through reset is seen as a press once debounced.
    wait_neg(7);
    check("held_c7_show", 64'(showing), 64'd0);
    wait_neg(1);
    check("held_c8_show", 64'(showing), 64'd1);
    wait_neg(1);
    check_all("held_press", D_P2, 2'd2, 1'b1);

    // Non-decimal nibble blanks only its own digit.
    btn2_n = 3'b110;
    wait_neg(9);
    check("nibble_c_seg", 64'(seg2), 64'(D_P0C));
    check("nibble_c_idx", 64'(idx2), 64'd0);
    check("nibble_c_show", 64'(showing2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/date_preset_display.md
# date_preset_display

Parametrised preset-date display controller for the board's seven-segment bank. Debounces active-low push buttons, latches the selected BCD date preset and drives NUM_DIGITS active-low seven-segment digits from registers. An optional auto-rotate mode steps through all presets on a fixed period. It sits between the raw button pins and the HEX display pins at top level.

## Interface
Parameters:
- NUM_DIGITS, 6: digits driven; digit NUM_DIGITS-1 is leftmost.
- NUM_PRESETS, 3: presets and buttons; must be ≥2.
- PRESET_BCD, 72'h800817_800726_860822: packed BCD. Preset p, digit i is at [(p*NUM_DIGITS+i)*4 +: 4].
- DEBOUNCE_CYCLES, 500000: consecutive stable synced samples needed to accept a button level.
- ROTATE_CYCLES, 50000000: clocks per preset in auto mode.

Ports:
- clk  in  1: single clock.
- rst  in  1: asynchronous, active-high reset.
- btn_n  in  NUM_PRESETS: raw active-low buttons; bit p selects preset p.
- auto_en  in  1: synchronous level; 1 selects auto-rotate.
- seg  out  7*NUM_DIGITS: active-low segments. Digit i is at [7*i +: 7], bit order gfedcba (bit 6 = g).
- active_idx  out  $clog2(NUM_PRESETS): preset currently shown.
- showing  out  1: 1 when a preset is displayed, 0 when blank.

## Operation
- Each btn_n bit passes through a 2-flop synchroniser and then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synced samples that differ from the current level.
  - A 1→0 debounced transition produces a one-cycle press pulse.
- FSM states:
  - BLANK: seg all 1s, showing=0.
  - SHOW: latched preset, static.
  - AUTO: latched preset, rotating.
- Transitions:
  - BLANK + press p → SHOW, idx=p.
  - SHOW + press p with p≠idx → SHOW, idx=p.
  - SHOW + press p with p==idx → BLANK (toggle off).
  - BLANK or SHOW + auto_en=1 → AUTO. idx is kept if showing, else 0. Rotate timer is cleared.
  - AUTO: when the timer reaches ROTATE_CYCLES-1, idx increments, wrapping NUM_PRESETS-1→0, and the timer clears.
  - AUTO + press p → idx=p and timer clears. There is no toggle-off in AUTO.
  - AUTO + auto_en=0 → SHOW with current idx.
- Simultaneous press pulses: lowest index wins; the others are discarded.
- Press pulse and auto_en change in the same cycle: the auto_en transition is applied first, then the press rule of the resulting state.
- Decode: BCD 0–9 map to standard active-low codes. Codes 10–15 blank the digit (7'b1111111). All decode cases are fully specified; no latches.

## Timing
- Reset values:
  - State BLANK, seg all 1s, active_idx 0, showing 0.
  - Debounced levels 1 (released), all counters 0.
- Reset asserted mid-operation returns to these values immediately. A button still held after reset deasserts is seen as a press once debounced.
- Latency:
  - For a clean press, the first clk edge sampling btn_n[p]=0 is cycle 0.
  - Press pulse occurs at cycle DEBOUNCE_CYCLES+2.
  - State, active_idx and showing update at cycle DEBOUNCE_CYCLES+3.
  - seg updates at cycle DEBOUNCE_CYCLES+4.
- Bounces shorter than DEBOUNCE_CYCLES restart the counter and produce no pulse.
- Release produces no event.
- In AUTO, active_idx changes exactly every ROTATE_CYCLES clocks. seg follows one cycle later.

## Structure
- Package date_display_pkg:
  - SEG_BLANK constant.
  - Digit segment constants 0–9.
  - Function bcd_to_seg(4-bit) → 7-bit.
  - FSM state enum {BLANK, SHOW, AUTO}.
- Sub-module btn_debounce: synchroniser, counter and press pulse for one button; instantiated NUM_PRESETS times via generate.
- Top level: FSM, rotate timer, preset mux and registered decode.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, ROTATE_CYCLES=16, default presets.
- Reset → seg all 1s, showing=0, active_idx=0. Hold rst=1 mid-AUTO → same values, asynchronously.
- btn_n[0] held low → at cycle 8, seg digit5=7'b0000000 ('8'), digit4=7'b0000010 ('6'), digit3=7'b1000000 ('0'), digit0=7'b0100100 ('2'); showing=1, active_idx=0.
- btn_n[1] pulsed low for 3 cycles (bounce) → no change. Held for 10 cycles → active_idx=1, display 800726. Press btn 1 again → seg all 1s, showing=0.
- btn_n[0] and btn_n[2] pressed in the same cycle from BLANK → active_idx=0 only.
- auto_en=1 from SHOW idx 1 → active_idx 2 after 16 cycles, then 0 after 32 (wrap). Press btn 1 at cycle 20 → idx=1 and next step to 2 occurs 16 cycles later.
- PRESET_BCD digit = 4'hC → that digit drives 7'b1111111; the other digits are unaffected.
